// File: rtl/dc_exec.sv
`default_nettype none
// ============================================================================
// Module   : dc_exec
// Brief    : Pops DC sequence instructions and drives per-channel DAC codes.
// Revision : 1.0 - initial release
// ============================================================================
module dc_exec #(
   parameter int INSN_WIDTH = 72,
   parameter int N_CH       = 8,
   parameter int DAC_WIDTH  = 16
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_en,
   input  logic                             i_empty,
   input  logic [INSN_WIDTH-1:0]            i_insn,
   output logic                             o_next,
   output logic [N_CH-1:0][DAC_WIDTH-1:0]   o_dc,
   output logic                             o_trig,
   output logic                             o_busy,
   output logic                             o_err
);

   localparam int       c_CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam bit [3:0] c_OP_NOP = 4'd0;
   localparam bit [3:0] c_OP_SET = 4'd1;
   localparam bit [3:0] c_OP_RMP = 4'd2;
   localparam bit [3:0] c_OP_WAI = 4'd3;
   localparam bit [3:0] c_OP_TRG = 4'd4;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_RAMP = 2'd2} state_t;

   state_t                 r_state;
   logic [15:0]            r_cnt;
   logic [15:0]            r_hold;
   logic [DAC_WIDTH-1:0]   r_step;
   logic [DAC_WIDTH-1:0]   r_tgt;
   logic [c_CH_W-1:0]      r_ch;

   logic [3:0]             w_op;
   logic [4:0]             w_ch;
   logic [c_CH_W-1:0]      w_ch_idx;
   logic                   w_ch_ok;
   logic [DAC_WIDTH-1:0]   w_tgt;
   logic [DAC_WIDTH-1:0]   w_step;
   logic [15:0]            w_hold;
   logic [DAC_WIDTH-1:0]   w_cur;
   logic [DAC_WIDTH:0]     w_up;
   logic [DAC_WIDTH:0]     w_dn;
   logic [DAC_WIDTH-1:0]   w_next_val;
   logic                   w_unused;

   assign w_op     = i_insn[71:68];
   assign w_ch     = i_insn[20:16];
   assign w_ch_idx = w_ch[c_CH_W-1:0];
   assign w_ch_ok  = (32'(w_ch) < N_CH);
   assign w_tgt    = i_insn[15:0];
   assign w_step   = i_insn[47:32];
   assign w_hold   = i_insn[63:48];
   assign w_unused = &{i_insn[31:21], i_insn[67:64]};

   assign o_next = (r_state == S_IDLE) && i_en && !i_empty;
   assign o_busy = (r_state != S_IDLE);

   // One extra bit of headroom so a step can never wrap past the target.
   assign w_cur = o_dc[r_ch];
   assign w_up  = {1'b0, w_cur} + {1'b0, r_step};
   assign w_dn  = {1'b0, w_cur} - {1'b0, r_step};

   always_comb begin
      w_next_val = r_tgt;
      if (r_tgt > w_cur) begin
         if (w_up < {1'b0, r_tgt}) w_next_val = w_up[DAC_WIDTH-1:0];
      end else begin
         if (!w_dn[DAC_WIDTH] && (w_dn > {1'b0, r_tgt})) w_next_val = w_dn[DAC_WIDTH-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hold  <= '0;
         r_step  <= '0;
         r_tgt   <= '0;
         r_ch    <= '0;
         o_dc    <= '0;
         o_trig  <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         o_trig <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (o_next) begin
                  case (w_op)
                     c_OP_NOP: ;
                     c_OP_SET, c_OP_WAI, c_OP_TRG: begin
                        if (w_op == c_OP_SET && !w_ch_ok) begin
                           o_err <= 1'b1;
                        end else begin
                           if (w_op == c_OP_SET) o_dc[w_ch_idx] <= w_tgt;
                           if (w_op == c_OP_TRG) o_trig <= 1'b1;
                           if (w_hold != 16'd0) begin
                              r_state <= S_HOLD;
                              r_cnt   <= w_hold;
                           end
                        end
                     end
                     c_OP_RMP: begin
                        if (!w_ch_ok) begin
                           o_err <= 1'b1;
                        end else if (o_dc[w_ch_idx] != w_tgt) begin
                           r_state <= S_RAMP;
                           r_cnt   <= w_hold;
                           r_hold  <= w_hold;
                           r_step  <= (w_step == '0) ? DAC_WIDTH'(1) : w_step;
                           r_tgt   <= w_tgt;
                           r_ch    <= w_ch_idx;
                        end
                     end
                     default: o_err <= 1'b1;
                  endcase
               end
            end
            S_HOLD: begin
               r_cnt <= r_cnt - 16'd1;
               if (r_cnt <= 16'd1) r_state <= S_IDLE;
            end
            S_RAMP: begin
               // Release only once the final code is already on the output.
               if (w_cur == r_tgt) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == 16'd0) begin
                  o_dc[r_ch] <= w_next_val;
                  r_cnt      <= r_hold;
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dc_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_exec
// Brief    : Directed self-checking bench for dc_exec.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_exec;

   logic              clk;
   logic              rst;
   logic              en;
   logic              empty;
   logic [71:0]       insn;
   logic              nxt;
   logic [7:0][15:0]  dc;
   logic              trig;
   logic              busy;
   logic              err;

   int total = 0;
   int bad   = 0;

   logic [71:0]      q[$];
   int               pops[$];
   int               trigs[$];
   logic [7:0][15:0] hist[64];
   logic             busy_h[64];
   logic             err_h[64];

   dc_exec #(.INSN_WIDTH(72), .N_CH(8), .DAC_WIDTH(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en), .i_empty(empty), .i_insn(insn),
      .o_next(nxt), .o_dc(dc), .o_trig(trig), .o_busy(busy), .o_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [71:0] mk(input logic [3:0] op, input logic [4:0] ch,
                                      input logic [15:0] tgt, input logic [15:0] step,
                                      input logic [15:0] hold);
      logic [71:0] v;
      v = '0;
      v[71:68] = op;
      v[20:16] = ch;
      v[15:0]  = tgt;
      v[47:32] = step;
      v[63:48] = hold;
      return v;
   endfunction

   // Upstream model: presents q in order, advances on o_next; cycle 0 is the first presented cycle.
   task automatic run(input int n);
      int idx;
      idx = 0;
      pops.delete();
      trigs.delete();
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         empty = (idx >= q.size());
         insn  = empty ? '0 : q[idx];
         #1;
         hist[c]   = dc;
         busy_h[c] = busy;
         err_h[c]  = err;
         if (nxt) begin
            pops.push_back(c);
            idx++;
         end
         if (trig) trigs.push_back(c);
      end
      @(negedge clk);
      empty = 1'b1;
      insn  = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; empty = 1'b1; insn = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (dc !== '0)    begin bad++; $display("FAIL reset_dc got=%h exp=0", dc); end
      total++; if (trig !== 1'b0) begin bad++; $display("FAIL reset_trig got=%b exp=0", trig); end
      total++; if (err !== 1'b0)  begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      logic any_busy;
      q = '{mk(4'd1, 5'd2, 16'h1234, 16'd0, 16'd0), mk(4'd1, 5'd3, 16'h0042, 16'd0, 16'd0)};
      run(4);
      any_busy = busy_h[0] | busy_h[1] | busy_h[2] | busy_h[3];
      total++; if (pops.size() != 2 || pops[0] != 0 || pops[1] != 1) begin
         bad++; $display("FAIL b2b_pops got=%p exp={0,1}", pops); end
      total++; if (hist[1][2] !== 16'h1234) begin bad++; $display("FAIL b2b_ch2 got=%h exp=1234", hist[1][2]); end
      total++; if (hist[2][3] !== 16'h0042) begin bad++; $display("FAIL b2b_ch3 got=%h exp=0042", hist[2][3]); end
      total++; if (any_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b exp=0", any_busy); end
   endtask

   task automatic test_hold_trig();
      q = '{mk(4'd1, 5'd0, 16'h0100, 16'd0, 16'd3), mk(4'd3, 5'd0, 16'h0, 16'd0, 16'd5),
            mk(4'd4, 5'd0, 16'h0, 16'd0, 16'd0)};
      run(16);
      total++; if (pops.size() != 3 || pops[0] != 0 || pops[1] != 4 || pops[2] != 10) begin
         bad++; $display("FAIL hold_pops got=%p exp={0,4,10}", pops); end
      total++; if (trigs.size() != 1 || trigs[0] != 11) begin
         bad++; $display("FAIL trig_cycle got=%p exp={11}", trigs); end
      total++; if (hist[1][0] !== 16'h0100) begin bad++; $display("FAIL hold_ch0 got=%h exp=0100", hist[1][0]); end
      total++; if (busy_h[3] !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b exp=1", busy_h[3]); end
   endtask

   task automatic test_ramp();
      q = '{mk(4'd2, 5'd1, 16'h000A, 16'd4, 16'd1), mk(4'd2, 5'd1, 16'h0000, 16'd0, 16'd1),
            mk(4'd0, 5'd0, 16'h0, 16'd0, 16'd0)};
      run(32);
      total++; if (hist[2][1] !== 16'h0000) begin bad++; $display("FAIL ramp_t2 got=%h exp=0000", hist[2][1]); end
      total++; if (hist[3][1] !== 16'h0004) begin bad++; $display("FAIL ramp_t3 got=%h exp=0004", hist[3][1]); end
      total++; if (hist[5][1] !== 16'h0008) begin bad++; $display("FAIL ramp_t5 got=%h exp=0008", hist[5][1]); end
      total++; if (hist[7][1] !== 16'h000A) begin bad++; $display("FAIL ramp_t7 got=%h exp=000a", hist[7][1]); end
      total++; if (pops.size() != 3 || pops[0] != 0 || pops[1] != 8 || pops[2] != 30) begin
         bad++; $display("FAIL ramp_pops got=%p exp={0,8,30}", pops); end
      total++; if (hist[19][1] !== 16'h0005) begin bad++; $display("FAIL rampdn_t19 got=%h exp=0005", hist[19][1]); end
      total++; if (hist[28][1] !== 16'h0001) begin bad++; $display("FAIL rampdn_t28 got=%h exp=0001", hist[28][1]); end
      total++; if (hist[29][1] !== 16'h0000) begin bad++; $display("FAIL rampdn_t29 got=%h exp=0000", hist[29][1]); end
      total++; if (hist[29][0] !== 16'h0100) begin bad++; $display("FAIL ramp_other got=%h exp=0100", hist[29][0]); end
   endtask

   task automatic test_errors();
      q = '{mk(4'hF, 5'd0, 16'hBEEF, 16'd0, 16'd7), mk(4'd1, 5'd9, 16'hBEEF, 16'd0, 16'd7)};
      run(4);
      total++; if (pops.size() != 2 || pops[0] != 0 || pops[1] != 1) begin
         bad++; $display("FAIL err_pops got=%p exp={0,1}", pops); end
      total++; if (err_h[0] !== 1'b0) begin bad++; $display("FAIL err_t0 got=%b exp=0", err_h[0]); end
      total++; if (err_h[1] !== 1'b1 || err_h[3] !== 1'b1) begin
         bad++; $display("FAIL err_sticky got=%b%b exp=11", err_h[1], err_h[3]); end
      total++; if (hist[3] !== hist[0]) begin bad++; $display("FAIL err_dc got=%h exp=%h", hist[3], hist[0]); end
   endtask

   task automatic test_enable_reset();
      int seen;
      seen = 0;
      @(negedge clk);
      en = 1'b0; empty = 1'b0; insn = mk(4'd1, 5'd4, 16'h7777, 16'd0, 16'd0);
      for (int c = 0; c < 10; c++) begin
         #1;
         if (nxt !== 1'b0 || busy !== 1'b0) seen++;
         @(negedge clk);
      end
      total++; if (seen != 0) begin bad++; $display("FAIL en_hold got=%0d exp=0", seen); end
      en = 1'b1;
      #1;
      total++; if (nxt !== 1'b1) begin bad++; $display("FAIL en_pop got=%b exp=1", nxt); end
      @(negedge clk);
      empty = 1'b1;
      #1;
      total++; if (dc[4] !== 16'h7777) begin bad++; $display("FAIL en_ch4 got=%h exp=7777", dc[4]); end

      q = '{mk(4'd2, 5'd5, 16'h0100, 16'd1, 16'd0)};
      run(5);
      total++; if (busy_h[3] !== 1'b1 || hist[4][5] === 16'h0000) begin
         bad++; $display("FAIL rst_pre busy=%b ch5=%h exp busy=1 ch5!=0", busy_h[3], hist[4][5]); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (dc !== '0 || busy !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL rst_mid dc=%h busy=%b err=%b exp 0/0/0", dc, busy, err); end
      q = {};
      run(6);
      total++; if (hist[5][5] !== 16'h0000 || busy_h[5] !== 1'b0 || pops.size() != 0) begin
         bad++; $display("FAIL rst_noreexec ch5=%h busy=%b pops=%0d exp 0/0/0", hist[5][5], busy_h[5], pops.size()); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_hold_trig();
      test_ramp();
      test_errors();
      test_enable_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
